score_ctrl: RTL

- Game-score sequencer that owns the score0/score1 digits consumed by the VGA pixel generator.
- Latches single-cycle point events from two players and arbitrates simultaneous events round-robin.
- Commits score changes only at frame boundaries (vsync falling edge) so a digit never changes mid-frame; a post-point hold interval follows each commit.
- Detects the win condition and blinks the display in game-over.

---
 rtl/score_ctrl_if.sv | 29 ++
 rtl/score_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl_if.sv
// ---------------------------------------------------------------------------
// score_ctrl_if : frame/point inputs and score/display outputs of score_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface score_ctrl_if;
  logic       vsync;
  logic       start;
  logic       pt0;
  logic       pt1;
  logic [3:0] score0;
  logic [3:0] score1;
  logic [1:0] winner;
  logic       game_over;
  logic       blank;

  modport master (
    output vsync, start, pt0, pt1,
    input  score0, score1, winner, game_over, blank
  );

  modport slave (
    input  vsync, start, pt0, pt1,
    output score0, score1, winner, game_over, blank
  );
endinterface

`default_nettype wire

// File: rtl/score_ctrl.sv
// ---------------------------------------------------------------------------
// score_ctrl : frame-synchronous two-player score sequencer with win/blink
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module score_ctrl #(
  parameter int WIN_SCORE    = 5,
  parameter int HOLD_FRAMES  = 30,
  parameter int BLINK_FRAMES = 15
) (
  input  logic         clk,
  input  logic         rst,
  score_ctrl_if.slave  bus
);

  localparam logic [3:0] C_WIN_DIGIT  = 4'(WIN_SCORE);
  localparam logic [7:0] C_HOLD_LOAD  = 8'(HOLD_FRAMES);
  localparam logic [7:0] C_BLINK_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAY      = 2'd1,
    ST_HOLD      = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_score0, w_score0_nxt;
  logic [3:0] r_score1, w_score1_nxt;
  logic [1:0] r_winner, w_winner_nxt;
  logic       r_game_over, w_game_over_nxt;
  logic       r_blank, w_blank_nxt;
  logic       r_pend0, w_pend0_nxt;
  logic       r_pend1, w_pend1_nxt;
  logic       r_rr, w_rr_nxt;
  logic [7:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [7:0] r_blink_cnt, w_blink_cnt_nxt;
  logic       r_vsync_q;

  logic       w_frame_tick;
  logic       w_commit0;
  logic       w_commit1;
  logic [3:0] w_score0_inc;
  logic [3:0] w_score1_inc;

  assign w_frame_tick = r_vsync_q & ~bus.vsync;
  assign w_score0_inc = r_score0 + 4'd1;
  assign w_score1_inc = r_score1 + 4'd1;

  // Round-robin pointer only matters when both players are pending.
  assign w_commit0 = w_frame_tick && (r_state == ST_PLAY) && r_pend0 && (!r_pend1 || !r_rr);
  assign w_commit1 = w_frame_tick && (r_state == ST_PLAY) && r_pend1 && (!r_pend0 || r_rr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_score0    <= 4'd0;
      r_score1    <= 4'd0;
      r_winner    <= 2'd0;
      r_game_over <= 1'b0;
      r_blank     <= 1'b0;
      r_pend0     <= 1'b0;
      r_pend1     <= 1'b0;
      r_rr        <= 1'b0;
      r_hold_cnt  <= 8'd0;
      r_blink_cnt <= 8'd0;
      r_vsync_q   <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_score0    <= w_score0_nxt;
      r_score1    <= w_score1_nxt;
      r_winner    <= w_winner_nxt;
      r_game_over <= w_game_over_nxt;
      r_blank     <= w_blank_nxt;
      r_pend0     <= w_pend0_nxt;
      r_pend1     <= w_pend1_nxt;
      r_rr        <= w_rr_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_vsync_q   <= bus.vsync;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_score0_nxt    = r_score0;
    w_score1_nxt    = r_score1;
    w_winner_nxt    = r_winner;
    w_game_over_nxt = r_game_over;
    w_blank_nxt     = r_blank;
    w_rr_nxt        = r_rr;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_blink_cnt_nxt = r_blink_cnt;
    w_pend0_nxt     = 1'b0;
    w_pend1_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt     = ST_PLAY;
          w_score0_nxt    = 4'd0;
          w_score1_nxt    = 4'd0;
          w_winner_nxt    = 2'd0;
          w_game_over_nxt = 1'b0;
          w_blank_nxt     = 1'b0;
          w_rr_nxt        = 1'b0;
        end
      end

      ST_PLAY: begin
        if (r_pend0 && r_pend1 && w_frame_tick) begin
          w_rr_nxt = ~r_rr;
        end
        if (w_commit0) begin
          w_score0_nxt = w_score0_inc;
          if (w_score0_inc == C_WIN_DIGIT) begin
            w_state_nxt     = ST_GAME_OVER;
            w_winner_nxt    = 2'd1;
            w_game_over_nxt = 1'b1;
            w_blink_cnt_nxt = 8'd0;
            w_blank_nxt     = 1'b0;
          end else begin
            w_state_nxt    = ST_HOLD;
            w_hold_cnt_nxt = C_HOLD_LOAD;
          end
        end else if (w_commit1) begin
          w_score1_nxt = w_score1_inc;
          if (w_score1_inc == C_WIN_DIGIT) begin
            w_state_nxt     = ST_GAME_OVER;
            w_winner_nxt    = 2'd2;
            w_game_over_nxt = 1'b1;
            w_blink_cnt_nxt = 8'd0;
            w_blank_nxt     = 1'b0;
          end else begin
            w_state_nxt    = ST_HOLD;
            w_hold_cnt_nxt = C_HOLD_LOAD;
          end
        end
      end

      ST_HOLD: begin
        if (w_frame_tick) begin
          w_hold_cnt_nxt = r_hold_cnt - 8'd1;
          if (r_hold_cnt == 8'd1) begin
            w_state_nxt = ST_PLAY;
          end
        end
      end

      ST_GAME_OVER: begin
        // A restart on the same cycle as a frame boundary suppresses the blink step.
        if (bus.start) begin
          w_state_nxt     = ST_PLAY;
          w_score0_nxt    = 4'd0;
          w_score1_nxt    = 4'd0;
          w_winner_nxt    = 2'd0;
          w_game_over_nxt = 1'b0;
          w_blank_nxt     = 1'b0;
          w_rr_nxt        = 1'b0;
          w_blink_cnt_nxt = 8'd0;
        end else if (w_frame_tick) begin
          if (r_blink_cnt == C_BLINK_LAST) begin
            w_blank_nxt     = ~r_blank;
            w_blink_cnt_nxt = 8'd0;
          end else begin
            w_blink_cnt_nxt = r_blink_cnt + 8'd1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // New events beat a same-cycle commit; latches stay empty outside active play.
    if (((r_state == ST_PLAY) || (r_state == ST_HOLD)) && (w_state_nxt != ST_GAME_OVER)) begin
      w_pend0_nxt = bus.pt0 | (r_pend0 & ~w_commit0);
      w_pend1_nxt = bus.pt1 | (r_pend1 & ~w_commit1);
    end
  end

  assign bus.score0    = r_score0;
  assign bus.score1    = r_score1;
  assign bus.winner    = r_winner;
  assign bus.game_over = r_game_over;
  assign bus.blank     = r_blank;

endmodule

`default_nettype wire
